lap_stopwatch: RTL and testbench

- Upstream display source for the mode-select stage: produces the stopwatch `seg_data`/`seg_com` pair, which the mode selector routes to the 7-segment panel in the stopwatch state.
- Counts HH:MM:SS.cc from the 1 kHz system clock.
- Turns raw start/clear/lap button levels into clean edge events and runs a RUN/PAUSE/IDLE control FSM.
- Scans the 8-digit common-cathode display itself, one digit per clock.

---
 rtl/stopwatch_pkg.sv | 53 +++++
 rtl/seg7_decode.sv | 32 +++
 rtl/lap_stopwatch.sv | 195 +++++++++++++++++++
 tb/tb_lap_stopwatch.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch: FSM state encoding,
// BCD time layout, digit limits, 7-segment patterns and a BCD increment helper.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } sw_state_t;

   localparam int NUM_DIGITS = 8;

   localparam logic [7:0] CC_MAX = 8'h99;
   localparam logic [7:0] SS_MAX = 8'h59;
   localparam logic [7:0] MM_MAX = 8'h59;
   localparam logic [7:0] HH_MAX = 8'h99;

   // bit7..bit0 = a,b,c,d,e,f,g,dp; dp left clear here, merged by the decoder
   localparam logic [7:0] SEG_0     = 8'hFC;
   localparam logic [7:0] SEG_1     = 8'h60;
   localparam logic [7:0] SEG_2     = 8'hDA;
   localparam logic [7:0] SEG_3     = 8'hF2;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'hB6;
   localparam logic [7:0] SEG_6     = 8'hBE;
   localparam logic [7:0] SEG_7     = 8'hE0;
   localparam logic [7:0] SEG_8     = 8'hFE;
   localparam logic [7:0] SEG_9     = 8'hF6;
   localparam logic [7:0] SEG_BLANK = 8'h00;

   localparam logic [7:0] SEG_COM_IDLE = 8'hFF;

   // HH:MM:SS.cc, two BCD digits per field, HH tens in the top nibble
   typedef struct packed {
      logic [7:0] hh;
      logic [7:0] mm;
      logic [7:0] ss;
      logic [7:0] cc;
   } bcd_time_t;

   // Two-digit BCD increment that wraps to 00 after reaching lim
   function automatic logic [7:0] bcd2_inc(input logic [7:0] v, input logic [7:0] lim);
      logic [7:0] r;
      if (v == lim)
         r = 8'h00;
      else if (v[3:0] == 4'd9)
         r = {v[7:4] + 4'd1, 4'd0};
      else
         r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit plus decimal point to 7-segment pattern (1 = segment on).
// Codes 10-15 produce a fully blank pattern, dp included.
module seg7_decode
   import stopwatch_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       dp,
   output logic [7:0] seg
);

   logic [7:0] pat;

   // Digit lookup, dp merged only for valid BCD codes
   always_comb begin
      pat = SEG_BLANK;
      case (bcd)
         4'd0:    pat = SEG_0;
         4'd1:    pat = SEG_1;
         4'd2:    pat = SEG_2;
         4'd3:    pat = SEG_3;
         4'd4:    pat = SEG_4;
         4'd5:    pat = SEG_5;
         4'd6:    pat = SEG_6;
         4'd7:    pat = SEG_7;
         4'd8:    pat = SEG_8;
         4'd9:    pat = SEG_9;
         default: pat = SEG_BLANK;
      endcase
      seg = (bcd <= 4'd9) ? {pat[7:1], dp} : SEG_BLANK;
   end

endmodule

// File: rtl/lap_stopwatch.sv
// Lap stopwatch: HH:MM:SS.cc BCD counter with start/clear control FSM and
// an 8-digit multiplexed common-cathode display driver.
// Optional lap-hold freeze of the display is built when LAP_HOLD_EN is defined;
// otherwise the lap input is unused and lap_hold is tied low.
//
// state | meaning
// IDLE  | counter and prescaler held at zero, waiting for start
// RUN   | prescaler advancing, counter incrementing on each tick
// PAUSE | counter and prescaler frozen; start resumes, clear returns to IDLE
module lap_stopwatch
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ  = 1000,
   parameter int TICK_HZ = 100
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       clear,
   input  logic       lap,
   output logic [7:0] seg_data,
   output logic [7:0] seg_com,
   output logic       running,
   output logic       lap_hold
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW  = $clog2(NUM_DIGITS);

`ifdef LAP_HOLD_EN
   localparam int NB = 3;
   logic [NB-1:0] btn_raw;
   assign btn_raw = {lap, clear, start};
`else
   localparam int NB = 2;
   logic [NB-1:0] btn_raw;
   logic          unused_lap;
   assign btn_raw    = {clear, start};
   assign unused_lap = lap;
`endif

   logic [NB-1:0] sync1, sync2, sync3, btn_pulse;
   logic          start_p, clear_p;
   sw_state_t     state;
   logic [PW-1:0] presc;
   logic          tick, zero_cnt;
   bcd_time_t     cnt, cnt_nxt, disp;
   logic [NUM_DIGITS-1:0][3:0] dig;
   logic [IW-1:0] idx;
   logic [3:0]    cur_bcd;
   logic          cur_dp;
   logic [7:0]    seg_nxt;

   // Two-flop synchronizer then a registered rising-edge pulse per button
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1     <= '0;
         sync2     <= '0;
         sync3     <= '0;
         btn_pulse <= '0;
      end else begin
         sync1     <= btn_raw;
         sync2     <= sync1;
         sync3     <= sync2;
         btn_pulse <= sync2 & ~sync3;
      end
   end

   assign start_p = btn_pulse[0];
   assign clear_p = btn_pulse[1];

   // Control FSM; running (and lap_hold when built) registered alongside state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         running <= 1'b0;
`ifdef LAP_HOLD_EN
         lap_hold <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start_p) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            RUN: begin
               if (start_p) begin
                  state   <= PAUSE;
                  running <= 1'b0;
`ifdef LAP_HOLD_EN
                  lap_hold <= 1'b0;
`endif
               end
`ifdef LAP_HOLD_EN
               else if (btn_pulse[2]) begin
                  lap_hold <= ~lap_hold;
               end
`endif
            end
            PAUSE: begin
               if (clear_p) begin
                  state <= IDLE;
               end else if (start_p) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               running <= 1'b0;
            end
         endcase
      end
   end

   assign zero_cnt = (state == IDLE) || ((state == PAUSE) && clear_p);
   assign tick     = (state == RUN) && (presc == PW'(DIV - 1));

   // Prescaler: advances in RUN, holds in PAUSE, zeroed in IDLE
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         presc <= '0;
      else if (zero_cnt)
         presc <= '0;
      else if (state == RUN)
         presc <= tick ? '0 : presc + PW'(1);
   end

   // Ripple carry through all four BCD fields within one cycle
   always_comb begin
      cnt_nxt    = cnt;
      cnt_nxt.cc = bcd2_inc(cnt.cc, CC_MAX);
      if (cnt.cc == CC_MAX)
         cnt_nxt.ss = bcd2_inc(cnt.ss, SS_MAX);
      if ((cnt.cc == CC_MAX) && (cnt.ss == SS_MAX))
         cnt_nxt.mm = bcd2_inc(cnt.mm, MM_MAX);
      if ((cnt.cc == CC_MAX) && (cnt.ss == SS_MAX) && (cnt.mm == MM_MAX))
         cnt_nxt.hh = bcd2_inc(cnt.hh, HH_MAX);
   end

   // Time counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (zero_cnt)
         cnt <= '0;
      else if (tick)
         cnt <= cnt_nxt;
   end

`ifdef LAP_HOLD_EN
   bcd_time_t snap;

   // Snapshot taken on the same lap edge that sets lap_hold
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         snap <= '0;
      else if ((state == RUN) && btn_pulse[2] && !lap_hold && !start_p)
         snap <= cnt;
   end

   assign disp = lap_hold ? snap : cnt;
`else
   assign lap_hold = 1'b0;
   assign disp     = cnt;
`endif

   assign dig     = disp;
   assign cur_bcd = dig[IW'(NUM_DIGITS - 1) - idx];
   assign cur_dp  = (idx == IW'(1)) || (idx == IW'(3)) || (idx == IW'(5));

   seg7_decode u_seg7_decode (
      .bcd (cur_bcd),
      .dp  (cur_dp),
      .seg (seg_nxt)
   );

   // Display scan: outputs registered one clock behind the index they encode
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx      <= '0;
         seg_data <= SEG_BLANK;
         seg_com  <= SEG_COM_IDLE;
      end else begin
         idx      <= idx + IW'(1);
         seg_data <= seg_nxt;
         seg_com  <= ~(8'h80 >> idx);
      end
   end

endmodule

// File: tb/tb_lap_stopwatch.sv
// Self-checking bench for lap_stopwatch at default parameters (10 clocks per tick).
// Lap-hold sequences are exercised when LAP_HOLD_EN is defined.
module tb_lap_stopwatch;
   import stopwatch_pkg::*;

   localparam int DIV = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       clear = 1'b0;
   logic       lap = 1'b0;
   logic [7:0] seg_data, seg_com;
   logic       running, lap_hold;

   int checks = 0;
   int failures = 0;
   logic [7:0] cap [8];

   typedef struct {
      logic      st;
      logic      cl;
      sw_state_t exp_state;
      logic      exp_run;
      logic      exp_zero;
      string     name;
   } vec_t;

   vec_t vecs [10];

   lap_stopwatch #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .clear    (clear),
      .lap      (lap),
      .seg_data (seg_data),
      .seg_com  (seg_com),
      .running  (running),
      .lap_hold (lap_hold)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_seg(input logic [3:0] d, input logic dp);
      logic [7:0] s;
      case (d)
         4'd0: s = 8'hFC;
         4'd1: s = 8'h60;
         4'd2: s = 8'hDA;
         4'd3: s = 8'hF2;
         4'd4: s = 8'h66;
         4'd5: s = 8'hB6;
         4'd6: s = 8'hBE;
         4'd7: s = 8'hE0;
         4'd8: s = 8'hFE;
         4'd9: s = 8'hF6;
         default: s = 8'h00;
      endcase
      return (d > 4'd9) ? 8'h00 : (s | {7'b0, dp});
   endfunction

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic s, input logic c, input logic l);
      start = s;
      clear = c;
      lap   = l;
      clks(4);
      start = 1'b0;
      clear = 1'b0;
      lap   = 1'b0;
      clks(4);
   endtask

   task automatic capture(input string name);
      logic [7:0] seen;
      logic [7:0] m;
      seen = 8'h00;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            m = 8'h80 >> i;
            if (seg_com == ~m) begin
               cap[i]  = seg_data;
               seen[i] = 1'b1;
            end
         end
      end
      chk({name, " com coverage"}, {24'b0, seen}, 32'hFF);
   endtask

   task automatic check_display(input string name, input logic [31:0] t);
      logic [3:0] d;
      logic       dp;
      capture(name);
      for (int i = 0; i < 8; i++) begin
         d  = 4'(t >> (28 - 4 * i));
         dp = (i == 1) || (i == 3) || (i == 5);
         chk($sformatf("%s digit%0d", name, i), {24'b0, cap[i]}, {24'b0, exp_seg(d, dp)});
      end
   endtask

   // Called right after reset release at a negedge; display must show all zeros
   task automatic seq_check(input string name);
      logic [7:0] exp_com [8];
      logic [7:0] exp_dat [8];
      exp_com = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
      exp_dat = '{8'hFC, 8'hFD, 8'hFC, 8'hFD, 8'hFC, 8'hFD, 8'hFC, 8'hFC};
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         chk($sformatf("%s com%0d", name, n), {24'b0, seg_com}, {24'b0, exp_com[n]});
         chk($sformatf("%s data%0d", name, n), {24'b0, seg_data}, {24'b0, exp_dat[n]});
      end
   endtask

   task automatic wait_running(input logic lvl, input int budget, input string name);
      int n;
      n = 0;
      while ((running !== lvl) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      chk(name, {31'b0, running}, {31'b0, lvl});
   endtask

   initial begin
      int rises, falls, rise_at, n;
      logic prev;
      logic [31:0] c0;

      vecs[0] = '{1'b0, 1'b1, IDLE,  1'b0, 1'b1, "clear in idle"};
      vecs[1] = '{1'b1, 1'b0, RUN,   1'b1, 1'b1, "start in idle"};
      vecs[2] = '{1'b0, 1'b1, RUN,   1'b1, 1'b0, "clear in run"};
      vecs[3] = '{1'b1, 1'b0, PAUSE, 1'b0, 1'b0, "start in run"};
      vecs[4] = '{1'b1, 1'b1, IDLE,  1'b0, 1'b1, "both in pause"};
      vecs[5] = '{1'b1, 1'b1, RUN,   1'b1, 1'b1, "both in idle"};
      vecs[6] = '{1'b1, 1'b1, PAUSE, 1'b0, 1'b0, "both in run"};
      vecs[7] = '{1'b1, 1'b0, RUN,   1'b1, 1'b0, "start in pause"};
      vecs[8] = '{1'b1, 1'b0, PAUSE, 1'b0, 1'b0, "start in run 2"};
      vecs[9] = '{1'b0, 1'b1, IDLE,  1'b0, 1'b1, "clear in pause"};

      // Reset values
      clks(2);
      chk("reset seg_data", {24'b0, seg_data}, 32'h00);
      chk("reset seg_com", {24'b0, seg_com}, 32'hFF);
      chk("reset running", {31'b0, running}, 32'h0);
      chk("reset lap_hold", {31'b0, lap_hold}, 32'h0);
      chk("reset cnt", dut.cnt, 32'h0);
      rst = 1'b1;
      seq_check("release");

      // Start held 50 clocks: one transition, 3 clocks after first sample
      start = 1'b1;
      rises = 0;
      falls = 0;
      rise_at = 0;
      prev = running;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         if (running && !prev) begin
            rises++;
            rise_at = i;
         end
         if (!running && prev) falls++;
         prev = running;
      end
      start = 1'b0;
      chk("held start rises", rises, 1);
      chk("held start falls", falls, 0);
      chk("start latency edge", rise_at, 4);
      chk("held start state", 32'(dut.state), 32'(RUN));

      // Wrap from 99:59:59.99
      n = 0;
      while ((int'(dut.presc) != DIV - 1) && (n < 40)) begin
         @(negedge clk);
         n++;
      end
      chk("presc reach terminal", 32'(n < 40), 32'h1);
      force dut.cnt = 32'h99595999;
      #1;
      release dut.cnt;
      chk("preload held", dut.cnt, 32'h99595999);
      @(negedge clk);
      chk("wrap cnt", dut.cnt, 32'h0);
      chk("wrap running", {31'b0, running}, 32'h1);
      chk("wrap state", 32'(dut.state), 32'(RUN));

      rst = 1'b0;
      clks(2);
      rst = 1'b1;
      clks(2);

      // FSM vector table
      for (int v = 0; v < 10; v++) begin
         press(vecs[v].st, vecs[v].cl, 1'b0);
         chk({vecs[v].name, " state"}, 32'(dut.state), 32'(vecs[v].exp_state));
         chk({vecs[v].name, " running"}, {31'b0, running}, {31'b0, vecs[v].exp_run});
         chk({vecs[v].name, " zero"}, 32'(dut.cnt == 32'h0), {31'b0, vecs[v].exp_zero});
         c0 = dut.cnt;
         clks(20);
         chk({vecs[v].name, " counting"}, 32'(dut.cnt != c0), {31'b0, vecs[v].exp_run});
      end

      // 1000 clocks after RUN entry = 100 ticks
      start = 1'b1;
      wait_running(1'b1, 10, "1s run entry");
      start = 1'b0;
      clks(1000);
      chk("1s cnt", dut.cnt, 32'h00000100);
      press(1'b1, 1'b0, 1'b0);
      chk("1s paused", 32'(dut.state), 32'(PAUSE));
      check_display("1s disp", 32'h00000100);
      chk("1s s-ones seg", {24'b0, cap[5]}, 32'h61);
      chk("1s cc-ones seg", {24'b0, cap[7]}, 32'hFC);

      // Reset mid-count
      press(1'b1, 1'b0, 1'b0);
      clks(150);
      chk("midcount nonzero", 32'(dut.cnt >= 32'h100), 32'h1);
      rst = 1'b0;
      #1;
      chk("async seg_data", {24'b0, seg_data}, 32'h00);
      chk("async seg_com", {24'b0, seg_com}, 32'hFF);
      chk("async running", {31'b0, running}, 32'h0);
      @(posedge clk);
      #1;
      chk("midreset seg_data", {24'b0, seg_data}, 32'h00);
      chk("midreset seg_com", {24'b0, seg_com}, 32'hFF);
      chk("midreset cnt", dut.cnt, 32'h0);
      chk("midreset state", 32'(dut.state), 32'(IDLE));
      @(negedge clk);
      rst = 1'b1;
      seq_check("midreset release");
      chk("midreset idle running", {31'b0, running}, 32'h0);

`ifdef LAP_HOLD_EN
      start = 1'b1;
      wait_running(1'b1, 10, "lap run entry");
      start = 1'b0;
      clks(1997);
      lap = 1'b1;
      clks(4);
      lap = 1'b0;
      chk("lap set", {31'b0, lap_hold}, 32'h1);
      clks(300);
      chk("lap internal cnt", dut.cnt, 32'h00000230);
      check_display("lap frozen", 32'h00000200);
      chk("lap still held", {31'b0, lap_hold}, 32'h1);
      press(1'b0, 1'b0, 1'b1);
      chk("lap second clears", {31'b0, lap_hold}, 32'h0);
      capture("lap live");
      chk("lap live cc-tens", {24'b0, cap[6]}, {24'b0, exp_seg(4'd3, 1'b0)});
      chk("lap live s-ones", {24'b0, cap[5]}, {24'b0, exp_seg(4'd2, 1'b1)});
      press(1'b0, 1'b0, 1'b1);
      chk("lap set again", {31'b0, lap_hold}, 32'h1);
      press(1'b1, 1'b0, 1'b0);
      chk("pause clears lap", {31'b0, lap_hold}, 32'h0);
      chk("pause after lap", {31'b0, running}, 32'h0);
      press(1'b0, 1'b0, 1'b1);
      chk("lap in pause ignored", {31'b0, lap_hold}, 32'h0);
`else
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b0, 1'b1);
      chk("lap disabled hold", {31'b0, lap_hold}, 32'h0);
      chk("lap disabled running", {31'b0, running}, 32'h1);
      c0 = dut.cnt;
      clks(20);
      chk("lap disabled counting", 32'(dut.cnt != c0), 32'h1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
